ahb_apb_bridge_mc: RTL

Parametrised AHB-Lite slave to APB3 master bridge serving `NUM_SLV` APB peripherals from one AHB slot. It is the next generation of the project's fixed three-peripheral bridge. It adds configurable data, address and peripheral count, and `Pready` wait states. It also adds `Pslverr` to AHB ERROR mapping and a two-cycle ERROR response for unmapped addresses. It sits between the AHB interconnect and the APB peripheral cluster.

---
 rtl/ahb_apb_bridge_mc_pkg.sv | 31 +++
 rtl/ahb_apb_bridge_mc_if.sv | 37 +++
 rtl/ahb_apb_bridge_mc_decode.sv | 27 ++
 rtl/ahb_apb_bridge_mc.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_bridge_mc_pkg.sv
// Shared encodings for the multi-peripheral AHB-Lite to APB3 bridge:
// AHB transfer types, response codes and the bridge FSM states.
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WWAIT  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_e;

  // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
  function automatic logic is_active_trans(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/ahb_apb_bridge_mc_if.sv
// Bus bundle for the bridge: AHB-Lite slave side plus APB3 master side.
// The bridge takes the slave modport, the driving environment the master one.
interface ahb_apb_bridge_mc_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 3
);

  logic              Hwrite;
  logic              Hreadyin;
  logic [1:0]        Htrans;
  logic [ADDR_W-1:0] Haddr;
  logic [DATA_W-1:0] Hwdata;
  logic              Hreadyout;
  logic [1:0]        Hresp;
  logic [DATA_W-1:0] Hrdata;

  logic [NUM_SLV-1:0] Pselx;
  logic               Penable;
  logic               Pwrite;
  logic [ADDR_W-1:0]  Paddr;
  logic [DATA_W-1:0]  Pwdata;
  logic [DATA_W-1:0]  Prdata;
  logic               Pready;
  logic               Pslverr;

  modport slave (
    input  Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata, Pready, Pslverr,
    output Hreadyout, Hresp, Hrdata, Pselx, Penable, Pwrite, Paddr, Pwdata
  );

  modport master (
    output Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata, Pready, Pslverr,
    input  Hreadyout, Hresp, Hrdata, Pselx, Penable, Pwrite, Paddr, Pwdata
  );

endinterface

// File: rtl/ahb_apb_bridge_mc_decode.sv
// Combinational peripheral decoder: maps an AHB address onto one of NUM_SLV
// equally sized regions starting at BASE and flags addresses outside them.
module apb_addr_decode #(
  parameter int                ADDR_W      = 32,
  parameter int                NUM_SLV     = 3,
  parameter logic [ADDR_W-1:0] BASE        = 32'h8000_0000,
  parameter int                REGION_LOG2 = 24,
  parameter int                IDX_W       = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
  input  logic [ADDR_W-1:0] haddr,
  output logic              valid,
  output logic [IDX_W-1:0]  idx
);

  logic [ADDR_W-1:0] offset_s;
  logic [ADDR_W-1:0] region_s;

  // Region number is compared at full width so aliasing high regions
  // can never fold back onto a real peripheral.
  always_comb begin
    offset_s = haddr - BASE;
    region_s = offset_s >> REGION_LOG2;
    valid    = (haddr >= BASE) && (region_s < ADDR_W'(NUM_SLV));
    idx      = region_s[IDX_W-1:0];
  end

endmodule

// File: rtl/ahb_apb_bridge_mc.sv
// AHB-Lite slave to APB3 master bridge serving NUM_SLV peripherals from one
// AHB slot, with Pready wait states, Pslverr mapping and a two-cycle ERROR
// response for unmapped addresses.
module ahb_apb_bridge_mc
  import ahb_apb_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_SLV     = 3,
  parameter logic [ADDR_W-1:0] BASE        = 32'h8000_0000,
  parameter int                REGION_LOG2 = 24
) (
  input logic                  Hclk,
  input logic                  Hreset,
  ahb_apb_bridge_mc_if.slave   bus
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [NUM_SLV-1:0] SEL_LSB = NUM_SLV'(1);

  state_e             state_r;
  state_e             state_nxt_s;
  logic [ADDR_W-1:0]  addr_r;
  logic               write_r;
  logic [IDX_W-1:0]   idx_r;
  logic [DATA_W-1:0]  wdata_r;
  logic [DATA_W-1:0]  rdata_r;

  logic               dec_valid_s;
  logic [IDX_W-1:0]   dec_idx_s;
  logic               hreadyout_s;
  logic [1:0]         hresp_s;
  logic               accept_s;
  logic               apb_active_s;
  logic               rd_done_s;

  apb_addr_decode #(
    .ADDR_W      (ADDR_W),
    .NUM_SLV     (NUM_SLV),
    .BASE        (BASE),
    .REGION_LOG2 (REGION_LOG2),
    .IDX_W       (IDX_W)
  ) u_decode (
    .haddr (bus.Haddr),
    .valid (dec_valid_s),
    .idx   (dec_idx_s)
  );

  // Where a freshly accepted transfer goes, identical from IDLE, ACCESS and ERR2.
  function automatic state_e accept_target(input logic valid, input logic wr);
    if (!valid) begin
      return ST_ERR1;
    end else if (wr) begin
      return ST_WWAIT;
    end else begin
      return ST_SETUP;
    end
  endfunction

  // AHB handshake outputs as a function of state and the APB completion.
  always_comb begin
    hreadyout_s = 1'b1;
    hresp_s     = HRESP_OKAY;
    case (state_r)
      ST_IDLE:  hreadyout_s = 1'b1;
      ST_WWAIT: hreadyout_s = 1'b0;
      ST_SETUP: hreadyout_s = 1'b0;
      ST_ACCESS: begin
        if (!bus.Pready) begin
          hreadyout_s = 1'b0;
        end else if (bus.Pslverr) begin
          hreadyout_s = 1'b0;
          hresp_s     = HRESP_ERROR;
        end else begin
          hreadyout_s = 1'b1;
        end
      end
      ST_ERR1: begin
        hreadyout_s = 1'b0;
        hresp_s     = HRESP_ERROR;
      end
      ST_ERR2: begin
        hreadyout_s = 1'b1;
        hresp_s     = HRESP_ERROR;
      end
      default: hreadyout_s = 1'b1;
    endcase
  end

  assign accept_s = is_active_trans(bus.Htrans) && bus.Hreadyin && hreadyout_s;

  // Next-state selection; completion cycles may chain straight into a new transfer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = accept_target(dec_valid_s, bus.Hwrite);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WWAIT: state_nxt_s = ST_SETUP;
      ST_SETUP: state_nxt_s = ST_ACCESS;
      ST_ACCESS: begin
        if (!bus.Pready) begin
          state_nxt_s = ST_ACCESS;
        end else if (bus.Pslverr) begin
          state_nxt_s = ST_ERR2;
        end else if (accept_s) begin
          state_nxt_s = accept_target(dec_valid_s, bus.Hwrite);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ERR1: state_nxt_s = ST_ERR2;
      ST_ERR2: begin
        if (accept_s) begin
          state_nxt_s = accept_target(dec_valid_s, bus.Hwrite);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Address-phase capture of address, direction and decoded peripheral.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      addr_r  <= '0;
      write_r <= 1'b0;
      idx_r   <= '0;
    end else if (accept_s) begin
      addr_r  <= bus.Haddr;
      write_r <= bus.Hwrite;
      idx_r   <= dec_idx_s;
    end
  end

  // Write data arrives one cycle after the address phase.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      wdata_r <= '0;
    end else if (state_r == ST_WWAIT) begin
      wdata_r <= bus.Hwdata;
    end
  end

  assign rd_done_s = (state_r == ST_ACCESS) && bus.Pready && !write_r;

  // Read data holding register so Hrdata stays defined between reads.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      rdata_r <= '0;
    end else if (rd_done_s) begin
      rdata_r <= bus.Prdata;
    end
  end

  assign apb_active_s  = (state_r == ST_SETUP) || (state_r == ST_ACCESS);

  assign bus.Hreadyout = hreadyout_s;
  assign bus.Hresp     = hresp_s;
  assign bus.Hrdata    = rd_done_s ? bus.Prdata : rdata_r;
  assign bus.Pselx     = apb_active_s ? (SEL_LSB << idx_r) : '0;
  assign bus.Penable   = (state_r == ST_ACCESS);
  assign bus.Pwrite    = write_r;
  assign bus.Paddr     = addr_r;
  assign bus.Pwdata    = wdata_r;

endmodule
